// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor controller: runs one 1-bit full subtractor over WIDTH
// cycles, LSB first, producing A - B - borrow_in behind a start/ready handshake.

module serial_subtract_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff_c,
    output logic o_bout_c
);

    assign o_diff_c = i_a ^ i_b ^ i_bin;
    assign o_bout_c = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

module serial_subtract_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             borrow_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res_sh;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_zero;

    logic             w_d;
    logic             w_bo;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_res_full;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;

    serial_subtract_bit u_bit (
        .i_a      (r_a_sh[0]),
        .i_b      (r_b_sh[0]),
        .i_bin    (r_brw),
        .o_diff_c (w_d),
        .o_bout_c (w_bo)
    );

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // Current bit joined with the partial result: becomes diff on the last bit.
    assign w_res_full = {w_d, r_res_sh};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_RUN:   w_busy  = 1'b1;
            S_DONE:  w_done  = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Operand shifters, borrow chain and bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= op_a;
            r_b_sh   <= op_b;
            r_brw    <= borrow_in;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_full[WIDTH-1:1];
            r_brw    <= w_bo;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers hold between completions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_diff       <= w_res_full;
            r_borrow_out <= w_bo;
            r_zero       <= (w_res_full == '0);
        end
    end

    assign ready      = w_ready;
    assign busy       = w_busy;
    assign done       = w_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign zero       = r_zero;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl: per-cycle comparison against
// a timeline/arithmetic model, plus literal vectors and randomized traffic.

module tb_serial_subtract_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             borrow_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;

    // Model: cycles remaining until ready, plus the arithmetic result
    int               m_timer = 0;
    int               m_accepts = 0;
    bit               m_init = 1'b0;
    logic [WIDTH-1:0] m_diff = '0;
    logic             m_bo = 1'b0;
    logic             m_zero = 1'b0;
    logic [WIDTH-1:0] m_pend_d = '0;
    logic             m_pend_bo = 1'b0;

    always #5 clk = ~clk;

    serial_subtract_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .borrow_in  (borrow_in),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_timer = 0;
            m_diff  = '0;
            m_bo    = 1'b0;
            m_zero  = 1'b0;
            m_init  = 1'b1;
        end else if (m_timer == 0) begin
            if (start) begin
                {m_pend_bo, m_pend_d} = {1'b0, op_a} - {1'b0, op_b} - (WIDTH+1)'(borrow_in);
                m_timer = WIDTH + 1;
                m_accepts++;
            end
        end else begin
            m_timer--;
            if (m_timer == 1) begin
                m_diff = m_pend_d;
                m_bo   = m_pend_bo;
                m_zero = (m_pend_d == '0);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("ready", 32'(ready), 32'(m_timer == 0));
            chk("busy", 32'(busy), 32'(m_timer > 1));
            chk("done", 32'(done), 32'(m_timer == 1));
            chk("diff", 32'(diff), 32'(m_diff));
            chk("borrow_out", 32'(borrow_out), 32'(m_bo));
            chk("zero", 32'(zero), 32'(m_zero));
        end
        if (done) done_cnt++;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] exp_d, input logic exp_bo,
                          input logic exp_z);
        int lat = 0;
        wait_ready();
        start = 1'b1; op_a = a; op_b = b; borrow_in = bin;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); borrow_in = 1'($urandom);
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(WIDTH));
        chk({name, "_diff"}, 32'(diff), 32'(exp_d));
        chk({name, "_borrow"}, 32'(borrow_out), 32'(exp_bo));
        chk({name, "_zero"}, 32'(zero), 32'(exp_z));
        chk({name, "_model_diff"}, 32'(m_diff), 32'(exp_d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done;
        int base_acc;
        int ncyc;
        int ndone;
        int last_done;
        int gap_bad;

        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; borrow_in = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        rst_n = 1'b1;

        run_op("t05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("t03m05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("t00m00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("tA5mA5", 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1);
        run_op("tFFm00", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        run_op("t00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("t00mFFb", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);

        // Start pulsed mid-run is ignored
        wait_ready();
        base_done = done_cnt;
        start = 1'b1; op_a = 8'h05; op_b = 8'h03; borrow_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; op_a = 8'h10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        chk("midrun_done_count", 32'(done_cnt - base_done), 32'd1);
        chk("midrun_diff", 32'(diff), 32'h02);

        // Back-to-back with start held high
        wait_ready();
        start = 1'b1; op_a = 8'h37; op_b = 8'h12; borrow_in = 1'b0;
        ndone = 0; last_done = -1; gap_bad = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done) begin
                if (last_done >= 0 && (cyc - last_done) != WIDTH + 2) gap_bad++;
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        chk("hold_done_count", 32'(ndone >= 4), 32'd1);
        chk("hold_gap_errors", 32'(gap_bad), 32'd0);
        chk("hold_diff", 32'(diff), 32'h25);

        // Reset during bit 4 aborts the operation
        wait_ready();
        start = 1'b1; op_a = 8'h55; op_b = 8'h22; borrow_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        base_done = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_diff", 32'(diff), 32'd0);
        repeat (12) begin @(posedge clk); #1; end
        chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);
        run_op("t80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0);

        // Randomized traffic; the per-cycle compare process does the checking
        base_acc = m_accepts;
        ncyc = 0;
        while ((m_accepts - base_acc) < 1000 && ncyc < 40000) begin
            start = 1'($urandom);
            op_a = WIDTH'($urandom);
            op_b = WIDTH'($urandom);
            borrow_in = 1'($urandom);
            @(posedge clk); #1;
            ncyc++;
        end
        start = 1'b0;
        chk("random_ops_completed", 32'((m_accepts - base_acc) >= 1000), 32'd1);
        repeat (WIDTH + 4) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
